// File: rtl/risc_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package risc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  // Requester indices; also the encoding of the owner and last-grant bits.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/risc_arb_pick.sv
// Combinational 2-way grant between instruction fetch and load/store.
// Build option RISC_ARB_ROUND_ROBIN_EN: when defined, contention is resolved
// against the last-grant pointer; otherwise LS always beats IF.
module risc_arb_pick
  import risc_arb_pkg::*;
(
  input  logic if_valid,
  input  logic ls_valid,
`ifdef RISC_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic gnt_if,
  output logic gnt_ls
);

`ifdef RISC_ARB_ROUND_ROBIN_EN
  // On contention the port that did not win last time gets the grant.
  always_comb begin
    gnt_if = if_valid;
    gnt_ls = ls_valid;
    if (if_valid && ls_valid) begin
      gnt_ls = (last_grant == PORT_IF);
      gnt_if = (last_grant == PORT_LS);
    end
  end
`else
  // Fixed priority: a valid LS request always wins.
  always_comb begin
    gnt_ls = ls_valid;
    gnt_if = if_valid && !ls_valid;
  end
`endif

endmodule

// File: rtl/risc_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS),
// one transaction at a time: accept, issue command, await response, route it.
// Build option RISC_ARB_ROUND_ROBIN_EN selects round-robin arbitration with a
// 1-bit last-grant pointer; default is fixed LS-over-IF priority.
module risc_mem_arbiter
  import risc_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_rdata,

  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_we,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,

  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  logic       owner;
  logic       gnt_if;
  logic       gnt_ls;
  logic       accept;

`ifdef RISC_ARB_ROUND_ROBIN_EN
  logic last_grant;
`endif

  risc_arb_pick u_pick (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
`ifdef RISC_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .gnt_if     (gnt_if),
    .gnt_ls     (gnt_ls)
  );

  // Grants are only offered in IDLE; masked during reset so nothing looks
  // accepted in a cycle the FSM will discard.
  assign if_req_ready = !rst && (state == IDLE) && gnt_if;
  assign ls_req_ready = !rst && (state == IDLE) && gnt_ls;
  assign accept       = if_req_ready || ls_req_ready;

`ifdef RISC_ARB_ROUND_ROBIN_EN
  // Remember which port was granted last; moves only on a real grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_IF;
    end else if (accept) begin
      last_grant <= ls_req_ready ? PORT_LS : PORT_IF;
    end
  end
`endif

  // Transaction sequencer: latch the winner, hold the command until
  // mem_ready, then capture the response for the owning port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= PORT_IF;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rsp_rdata <= '0;
      ls_rsp_rdata <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_valid <= 1'b1;
            state     <= CMD;
            if (ls_req_ready) begin
              owner     <= PORT_LS;
              mem_addr  <= ls_req_addr;
              mem_we    <= ls_req_we;
              mem_wdata <= ls_req_wdata;
            end else begin
              owner     <= PORT_IF;
              mem_addr  <= if_req_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        CMD: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (owner == PORT_LS) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Self-checking bench for risc_mem_arbiter: directed scenarios with literal
// expectations plus a transaction-level reference model checked every cycle.
module tb_risc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_req_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [31:0] ls_req_addr = '0;
  logic        ls_req_we = 1'b0;
  logic [31:0] ls_req_wdata = '0;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  risc_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_rdata (if_rsp_rdata),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_addr  (ls_req_addr),
    .ls_req_we    (ls_req_we),
    .ls_req_wdata (ls_req_wdata),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_rdata (ls_rsp_rdata),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents seen by reads.
  function automatic logic [31:0] img(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory responder ----------------
  int rsp_lat = 1;     // cycles from handshake edge to rvalid
  int stall_val = 0;   // mem_ready-low cycles for the next command
  int stall_seq = 0;
  int spur_seq = 0;

  int          r_stall = 0;
  int          r_stall_seen = 0;
  int          r_spur_seen = 0;
  int          r_pend = 0;
  logic [31:0] r_data = '0;

  always @(posedge clk) begin
    logic        hs;
    logic [31:0] a;
    logic        w;
    hs = mem_valid && mem_ready;
    a  = mem_addr;
    w  = mem_we;
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (hs) begin
      r_pend = rsp_lat;
      // Junk data on writes: the arbiter must return 0 for stores.
      r_data = w ? 32'hA5A5A5A5 : img(a);
    end
    if (r_pend > 0) begin
      r_pend--;
      if (r_pend == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = r_data;
      end
    end
    if (spur_seq != r_spur_seen) begin
      r_spur_seen = spur_seq;
      mem_rvalid  = 1'b1;
      mem_rdata   = 32'hBAD0BAD0;
    end
    if (stall_seq != r_stall_seen) begin
      r_stall_seen = stall_seq;
      r_stall      = stall_val;
    end
    if (mem_valid && r_stall > 0) begin
      mem_ready = 1'b0;
      r_stall--;
    end else begin
      mem_ready = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // One in-flight transaction record; the memory command registers and the
  // response registers are the only visible state.
  bit          m_init = 0;
  bit          m_busy, m_sent;
  int          m_own;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_ls_rd;
  logic        m_we, m_if_v, m_ls_v;
`ifdef RISC_ARB_ROUND_ROBIN_EN
  int          m_last;
`endif

  // Returns -1 for no grant, 0 for IF, 1 for LS.
  function automatic int winner(input logic vi, input logic vl);
`ifdef RISC_ARB_ROUND_ROBIN_EN
    if (vi && vl) return (m_last == 0) ? 1 : 0;
`endif
    if (vl) return 1;
    if (vi) return 0;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    w = winner(if_req_valid, ls_req_valid);
    if (m_init) begin
      chk("if_req_ready", {31'b0, if_req_ready}, {31'b0, !rst && !m_busy && w == 0});
      chk("ls_req_ready", {31'b0, ls_req_ready}, {31'b0, !rst && !m_busy && w == 1});
      chk("mem_valid",    {31'b0, mem_valid},    {31'b0, m_busy && !m_sent});
      chk("mem_addr",     mem_addr,              m_addr);
      chk("mem_we",       {31'b0, mem_we},       {31'b0, m_we});
      chk("mem_wdata",    mem_wdata,             m_wdata);
      chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, m_if_v});
      chk("ls_rsp_valid", {31'b0, ls_rsp_valid}, {31'b0, m_ls_v});
      chk("if_rsp_rdata", if_rsp_rdata,          m_if_rd);
      chk("ls_rsp_rdata", ls_rsp_rdata,          m_ls_rd);
    end
    if (rst) begin
      m_init = 1; m_busy = 0; m_sent = 0; m_own = 0;
      m_addr = '0; m_we = 0; m_wdata = '0;
      m_if_v = 0; m_ls_v = 0; m_if_rd = '0; m_ls_rd = '0;
`ifdef RISC_ARB_ROUND_ROBIN_EN
      m_last = 0;
`endif
    end else if (m_init) begin
      m_if_v = 0;
      m_ls_v = 0;
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy = 1; m_sent = 0; m_own = w;
`ifdef RISC_ARB_ROUND_ROBIN_EN
          m_last = w;
`endif
          if (w == 1) begin
            m_addr = ls_req_addr; m_we = ls_req_we; m_wdata = ls_req_wdata;
          end else begin
            m_addr = if_req_addr; m_we = 0; m_wdata = '0;
          end
        end
      end else if (!m_sent) begin
        if (mem_ready) m_sent = 1;
      end else if (mem_rvalid) begin
        m_busy = 0;
        if (m_own == 1) begin
          m_ls_v = 1; m_ls_rd = m_we ? 32'h0 : mem_rdata;
        end else begin
          m_if_v = 1; m_if_rd = mem_rdata;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] got [4];
    logic [31:0] exp_g [4];
    int          n;
    logic        prev;

    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_if_rdata",  if_rsp_rdata, 32'd0);
    chk("rst_ls_rdata",  ls_rsp_rdata, 32'd0);

    // Zero-wait read from IF.
    cyc(); if_req_valid = 1; if_req_addr = 32'h100;
    @(negedge clk); chk("zw_if_ready", {31'b0, if_req_ready}, 32'd1);
    cyc(); if_req_valid = 0;
    @(negedge clk); chk("zw_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("zw_mem_addr", mem_addr, 32'h100);
    cyc(); cyc();
    @(negedge clk); chk("zw_if_rsp", {31'b0, if_rsp_valid}, 32'd1);
    chk("zw_if_rdata", if_rsp_rdata, 32'hDEADBEEF);
    chk("zw_ls_rsp", {31'b0, ls_rsp_valid}, 32'd0);

    // Contention: LS load 0x20 vs IF 0x10.
    cyc(); if_req_valid = 1; if_req_addr = 32'h10;
    ls_req_valid = 1; ls_req_addr = 32'h20; ls_req_we = 0;
    @(negedge clk); chk("ct_ls_ready", {31'b0, ls_req_ready}, 32'd1);
    chk("ct_if_ready", {31'b0, if_req_ready}, 32'd0);
    cyc(); ls_req_valid = 0;
    @(negedge clk); chk("ct_mem_addr_ls", mem_addr, 32'h20);
    cyc(); cyc();
    @(negedge clk); chk("ct_ls_rsp", {31'b0, ls_rsp_valid}, 32'd1);
    chk("ct_ls_rdata", ls_rsp_rdata, 32'h5A5A0020);
    chk("ct_if_ready2", {31'b0, if_req_ready}, 32'd1);
    cyc(); if_req_valid = 0;
    @(negedge clk); chk("ct_mem_addr_if", mem_addr, 32'h10);
    cyc(); cyc();
    @(negedge clk); chk("ct_if_rdata", if_rsp_rdata, 32'h5A5A0010);

    // Store with 3 cycles of backpressure.
    cyc(); stall_val = 3; stall_seq++;
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 32'h40; ls_req_wdata = 32'h12345678;
    @(negedge clk); chk("st_ls_ready", {31'b0, ls_req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin ls_req_valid = 0; ls_req_we = 0; ls_req_wdata = '0; end
      @(negedge clk);
      chk("st_hold_valid", {31'b0, mem_valid}, 32'd1);
      chk("st_hold_addr", mem_addr, 32'h40);
      chk("st_hold_wdata", mem_wdata, 32'h12345678);
    end
    cyc(); @(negedge clk); chk("st_released", {31'b0, mem_valid}, 32'd0);
    cyc(); @(negedge clk); chk("st_ls_rsp", {31'b0, ls_rsp_valid}, 32'd1);
    chk("st_ls_rdata", ls_rsp_rdata, 32'd0);

    // Spurious mem_rvalid in IDLE.
    cyc(); spur_seq++;
    cyc(); @(negedge clk);
    chk("sp_idle_if", {31'b0, if_rsp_valid}, 32'd0);
    chk("sp_idle_ls", {31'b0, ls_rsp_valid}, 32'd0);
    cyc(); @(negedge clk); chk("sp_idle_mv", {31'b0, mem_valid}, 32'd0);

    // Spurious mem_rvalid while in CMD (memory stalled).
    cyc(); stall_val = 3; stall_seq++; spur_seq++;
    if_req_valid = 1; if_req_addr = 32'h80;
    cyc(); if_req_valid = 0;
    cyc(); @(negedge clk);
    chk("sp_cmd_mv", {31'b0, mem_valid}, 32'd1);
    chk("sp_cmd_if", {31'b0, if_rsp_valid}, 32'd0);
    cyc(); cyc(); cyc(); cyc();
    @(negedge clk); chk("sp_cmd_done", {31'b0, if_rsp_valid}, 32'd1);
    chk("sp_cmd_rdata", if_rsp_rdata, 32'h5A5A0080);

    // Reset while waiting for a slow response.
    cyc(); rsp_lat = 3; if_req_valid = 1; if_req_addr = 32'h180;
    cyc(); if_req_valid = 0;
    cyc(); rst = 1;
    cyc(); rst = 0;
    @(negedge clk);
    chk("rs_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rs_mem_addr", mem_addr, 32'd0);
    chk("rs_if_rdata", if_rsp_rdata, 32'd0);
    cyc(); @(negedge clk); chk("rs_late_ignored", {31'b0, if_rsp_valid}, 32'd0);
    cyc(); @(negedge clk); chk("rs_late_ignored2", {31'b0, if_rsp_valid}, 32'd0);
    cyc(); rsp_lat = 1; if_req_valid = 1; if_req_addr = 32'h104;
    @(negedge clk); chk("rs_fresh_ready", {31'b0, if_req_ready}, 32'd1);
    cyc(); if_req_valid = 0;
    cyc(); cyc();
    @(negedge clk); chk("rs_fresh_rsp", {31'b0, if_rsp_valid}, 32'd1);
    chk("rs_fresh_rdata", if_rsp_rdata, 32'h5A5A0104);

    // Both ports continuously valid for four grants.
    cyc(); if_req_valid = 1; if_req_addr = 32'h200;
    ls_req_valid = 1; ls_req_addr = 32'h300; ls_req_we = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    n = 0; prev = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (mem_valid === 1'b1 && !prev) begin got[n] = mem_addr; n++; end
      prev = (mem_valid === 1'b1);
      cyc();
    end
    if_req_valid = 0; ls_req_valid = 0;
    chk("cont_grants", n, 4);
`ifdef RISC_ARB_ROUND_ROBIN_EN
    exp_g[0] = 32'h300; exp_g[1] = 32'h200; exp_g[2] = 32'h300; exp_g[3] = 32'h200;
`else
    exp_g[0] = 32'h300; exp_g[1] = 32'h300; exp_g[2] = 32'h300; exp_g[3] = 32'h300;
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), got[i], exp_g[i]);

    repeat (6) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
